// File: rtl/aes32_round_seq.sv
`timescale 1ns/1ps
// aes32_round_seq: runs a full AES block through the shared AES32 scalar crypto unit, 16 byte ops per round.
// Optional macro AES_SEQ_DECRYPT_EN adds decrypt_i and the equivalent-inverse-cipher path.
module aes32_round_seq #(
    parameter int NROUNDS = 10,
    localparam int RKW = $clog2(NROUNDS + 1)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start_i,
`ifdef AES_SEQ_DECRYPT_EN
    input  logic           decrypt_i,
`endif
    input  logic [127:0]   pt_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [127:0]   ct_o,
    output logic           rk_req_o,
    output logic [RKW-1:0] rk_idx_o,
    input  logic           rk_valid_i,
    input  logic [127:0]   rk_i,
    output logic           cu_req_o,
    output logic [9:0]     cu_op_o,
    output logic [31:0]    cu_rs1_o,
    output logic [31:0]    cu_rs2_o,
    input  logic           cu_ack_i,
    input  logic [31:0]    cu_result_i
);
    typedef enum logic [2:0] {S_IDLE, S_KEY0, S_KEYR, S_OPS, S_COMMIT, S_DONE} state_t;
    localparam logic [RKW-1:0] NR = RKW'(NROUNDS);

    state_t          state_q;
    logic [RKW-1:0]  r_q, r_d, rk_idx_q, next_idx;
    logic [1:0]      j_q, k_q, sel;
    logic [31:0]     acc_q, rk_next;
    logic [3:0][31:0] st_q, nxt_q;
    logic [2:0][31:0] rk_q;
    logic [127:0]    ct_q;
    logic            busy_q, done_q, rk_req_q, cu_req_q, dec_q, dec_in, last;
    logic [7:0]      op_base;

`ifdef AES_SEQ_DECRYPT_EN
    assign dec_in = decrypt_i;
`else
    assign dec_in = 1'b0;
`endif

    always_comb begin
        r_d      = r_q + 1'b1;
        next_idx = dec_q ? NR - r_d : r_d;
        last     = (r_q == NR);
        // Forward ShiftRows reads column j+k, the inverse reads column j-k.
        sel      = dec_q ? (j_q - k_q) : (j_q + k_q);
        case ({dec_q, last})
            2'b00:   op_base = 8'd152;
            2'b01:   op_base = 8'd136;
            2'b10:   op_base = 8'd184;
            default: op_base = 8'd168;
        endcase
        // Buffer holds round-key words 1..3; word 0 seeds the accumulator directly.
        case (j_q)
            2'd0:    rk_next = rk_q[0];
            2'd1:    rk_next = rk_q[1];
            default: rk_next = rk_q[2];
        endcase
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign ct_o     = ct_q;
    assign rk_req_o = rk_req_q;
    assign rk_idx_o = rk_idx_q;
    assign cu_req_o = cu_req_q;
    assign cu_op_o  = cu_req_q ? {k_q, op_base} : '0;
    assign cu_rs1_o = cu_req_q ? acc_q : '0;
    assign cu_rs2_o = cu_req_q ? st_q[sel] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            st_q     <= '0;
            nxt_q    <= '0;
            rk_q     <= '0;
            ct_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rk_req_q <= 1'b0;
            rk_idx_q <= '0;
            cu_req_q <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        st_q     <= pt_i;
                        dec_q    <= dec_in;
                        r_q      <= RKW'(1);
                        busy_q   <= 1'b1;
                        rk_req_q <= 1'b1;
                        rk_idx_q <= dec_in ? NR : '0;
                        state_q  <= S_KEY0;
                    end
                end
                S_KEY0: begin
                    if (rk_valid_i) begin
                        st_q     <= st_q ^ rk_i;
                        rk_idx_q <= dec_q ? NR - RKW'(1) : RKW'(1);
                        state_q  <= S_KEYR;
                    end
                end
                S_KEYR: begin
                    if (rk_valid_i) begin
                        rk_q     <= rk_i[127:32];
                        acc_q    <= rk_i[31:0];
                        j_q      <= '0;
                        k_q      <= '0;
                        rk_req_q <= 1'b0;
                        rk_idx_q <= '0;
                        cu_req_q <= 1'b1;
                        state_q  <= S_OPS;
                    end
                end
                S_OPS: begin
                    if (cu_ack_i) begin
                        acc_q <= cu_result_i;
                        k_q   <= k_q + 1'b1;
                        if (k_q == 2'd3) begin
                            nxt_q[j_q] <= cu_result_i;
                            if (j_q == 2'd3) begin
                                cu_req_q <= 1'b0;
                                state_q  <= S_COMMIT;
                            end else begin
                                j_q   <= j_q + 1'b1;
                                acc_q <= rk_next;
                            end
                        end
                    end
                end
                S_COMMIT: begin
                    st_q <= nxt_q;
                    if (last) begin
                        ct_q    <= nxt_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        r_q      <= r_d;
                        rk_req_q <= 1'b1;
                        rk_idx_q <= next_idx;
                        state_q  <= S_KEYR;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes32_round_seq.sv
`timescale 1ns/1ps
// tb_aes32_round_seq: FIPS-197 C.1 vectors through the sequencer with a behavioural AES32 unit and key source.
module tb_aes32_round_seq;
    logic         clk = 1'b0, reset_n = 1'b0, start_i = 1'b0, decrypt_i = 1'b0;
    logic [127:0] pt_i = '0, ct_o, rk_i;
    logic         busy_o, done_o, rk_req_o, rk_valid_i = 1'b0, cu_req_o, cu_ack_i = 1'b0;
    logic [3:0]   rk_idx_o;
    logic [9:0]   cu_op_o;
    logic [31:0]  cu_rs1_o, cu_rs2_o, cu_result_i;

    always #5 clk = ~clk;

    aes32_round_seq dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i),
`ifdef AES_SEQ_DECRYPT_EN
        .decrypt_i(decrypt_i),
`endif
        .pt_i(pt_i), .busy_o(busy_o), .done_o(done_o), .ct_o(ct_o),
        .rk_req_o(rk_req_o), .rk_idx_o(rk_idx_o), .rk_valid_i(rk_valid_i), .rk_i(rk_i),
        .cu_req_o(cu_req_o), .cu_op_o(cu_op_o), .cu_rs1_o(cu_rs1_o), .cu_rs2_o(cu_rs2_o),
        .cu_ack_i(cu_ack_i), .cu_result_i(cu_result_i)
    );

    logic [7:0]   sbox_t [256];
    logic [7:0]   isbox_t [256];
    logic [127:0] enc_rk [16];
    logic [127:0] dec_rk [16];
    bit           dec_mode = 0, stall_mode = 0;
    int           n_chk = 0, n_pass = 0;
    int           op_cnt = 0, rk_cnt = 0, done_cnt = 0, stab_err = 0, cu_wait = 0, rk_wait = 0;
    logic [9:0]   op_log [256];
    logic [31:0]  rs1_log [256];
    logic [31:0]  rs2_log [256];
    logic [3:0]   rk_log [16];
    logic         p_cu_req = 0, p_cu_ack = 0, p_rk_req = 0, p_rk_val = 0;
    logic [9:0]   p_op;
    logic [31:0]  p_rs1, p_rs2;
    logic [3:0]   p_idx;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
        return y;
    endfunction

    function automatic logic [31:0] inv_mix_word(input logic [31:0] c);
        logic [31:0] o;
        for (int i = 0; i < 4; i++)
            o[8*i +: 8] = gm(c[8*i +: 8], 8'd14) ^ gm(c[8*((i+1)%4) +: 8], 8'd11)
                        ^ gm(c[8*((i+2)%4) +: 8], 8'd13) ^ gm(c[8*((i+3)%4) +: 8], 8'd9);
        return o;
    endfunction

    // Behavioural AES32 ESMI/ESI/DSMI/DSI with byte-select in op[9:8].
    function automatic logic [31:0] cu_model(input logic [9:0] op, input logic [31:0] rs1, input logic [31:0] rs2);
        logic [1:0]  bs = op[9:8];
        logic [7:0]  x = rs2[8*bs +: 8];
        logic [7:0]  s;
        logic [31:0] u;
        logic [63:0] t;
        case (op[7:0])
            8'd152:  begin s = sbox_t[x];  u = {gm(s, 8'd3), s, s, gm(s, 8'd2)}; end
            8'd136:  begin s = sbox_t[x];  u = {24'h0, s}; end
            8'd184:  begin s = isbox_t[x]; u = {gm(s, 8'd11), gm(s, 8'd13), gm(s, 8'd9), gm(s, 8'd14)}; end
            8'd168:  begin s = isbox_t[x]; u = {24'h0, s}; end
            default: begin s = 8'h00;      u = 32'h0; end
        endcase
        t = {u, u} << (8 * bs);
        return rs1 ^ t[63:32];
    endfunction

    always_comb cu_result_i = cu_model(cu_op_o, cu_rs1_o, cu_rs2_o);
    assign rk_i = dec_mode ? dec_rk[rk_idx_o] : enc_rk[rk_idx_o];

    // Responder and monitor: drives ack/valid, logs completed transfers, checks stalled requests hold.
    always @(negedge clk) begin
        if (reset_n && p_cu_req && !p_cu_ack)
            if (!cu_req_o || cu_op_o != p_op || cu_rs1_o != p_rs1 || cu_rs2_o != p_rs2) stab_err++;
        if (reset_n && p_rk_req && !p_rk_val)
            if (!rk_req_o || rk_idx_o != p_idx) stab_err++;
        if (stall_mode) begin
            if (cu_req_o) begin
                if (cu_wait == 0) begin cu_ack_i = 1'b1; cu_wait = $urandom_range(0, 5); end
                else begin cu_ack_i = 1'b0; cu_wait--; end
            end else cu_ack_i = 1'b0;
            if (rk_req_o) begin
                if (rk_wait == 0) begin rk_valid_i = 1'b1; rk_wait = $urandom_range(0, 5); end
                else begin rk_valid_i = 1'b0; rk_wait--; end
            end else rk_valid_i = 1'b0;
        end else begin
            cu_ack_i   = 1'b1;
            rk_valid_i = 1'b1;
        end
        if (cu_req_o && cu_ack_i) begin
            if (op_cnt < 256) begin
                op_log[op_cnt] = cu_op_o; rs1_log[op_cnt] = cu_rs1_o; rs2_log[op_cnt] = cu_rs2_o;
            end
            op_cnt++;
        end
        if (rk_req_o && rk_valid_i) begin
            rk_log[rk_cnt % 16] = rk_idx_o;
            rk_cnt++;
        end
        if (done_o) done_cnt++;
        p_cu_req = cu_req_o; p_cu_ack = cu_ack_i; p_op = cu_op_o; p_rs1 = cu_rs1_o; p_rs2 = cu_rs2_o;
        p_rk_req = rk_req_o; p_rk_val = rk_valid_i; p_idx = rk_idx_o;
    end

    task automatic run(input logic [127:0] pt, input bit dec, input bit extra,
                       output logic [127:0] ct, output int cyc);
        op_cnt = 0; rk_cnt = 0; done_cnt = 0;
        @(negedge clk);
        pt_i = pt; decrypt_i = dec; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (!done_o && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start_i = extra && (cyc == 5 || cyc == 90);
            if (start_i) pt_i = {4{$urandom}};
        end
        ct = ct_o;
        start_i = extra;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        $display("run dec=%0d extra=%0d stall=%0d: ct=%032h cycles=%0d ops=%0d keys=%0d dones=%0d",
                 dec, extra, stall_mode, ct, cyc, op_cnt, rk_cnt, done_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] pt, ct_ref, ct, st1;
        logic [127:0] key;
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   inv, rcon;
        int           cyc, e;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);

        key = bswap(128'h000102030405060708090a0b0c0d0e0f);
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                for (int b = 0; b < 4; b++) t[8*b +: 8] = sbox_t[t[8*b +: 8]];
                t[7:0] = t[7:0] ^ rcon;
                rcon = gm(rcon, 8'd2);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin enc_rk[r] = '0; dec_rk[r] = '0; end
        for (int r = 0; r <= 10; r++) begin
            enc_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
            dec_rk[r] = enc_rk[r];
            if (r != 0 && r != 10)
                for (int c = 0; c < 4; c++) dec_rk[r][32*c +: 32] = inv_mix_word(enc_rk[r][32*c +: 32]);
        end

        pt     = bswap(128'h00112233445566778899aabbccddeeff);
        ct_ref = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_ct", ct_o, 128'h0);
        check("rst_reqs", {cu_req_o, rk_req_o, rk_idx_o, cu_op_o}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run(pt, 1'b0, 1'b0, ct, cyc);
        check("enc_ct", ct, ct_ref);
        check("enc_latency", cyc, 181);
        check("enc_done_cnt", done_cnt, 1);
        check("enc_key_cnt", rk_cnt, 11);
        check("enc_busy_after", busy_o, 1'b0);
        e = 0;
        for (int i = 0; i < 11; i++) if (rk_log[i] != 4'(i)) e++;
        check("enc_key_order", e, 0);
        e = 0;
        for (int i = 0; i < 16; i++) if (op_log[i] != 10'(152 + 256 * (i % 4))) e++;
        check("op_trace_r1", e, 0);
        e = 0;
        for (int i = 144; i < 160; i++) if (op_log[i] != 10'(136 + 256 * (i % 4))) e++;
        check("op_trace_r10", e, 0);
        st1 = pt ^ enc_rk[0];
        for (int k = 0; k < 4; k++) check($sformatf("rs2_col0_k%0d", k), rs2_log[k], st1[32*k +: 32]);
        check("rs1_first", rs1_log[0], enc_rk[1][31:0]);

        stall_mode = 1; stab_err = 0;
        run(pt, 1'b0, 1'b0, ct, cyc);
        stall_mode = 0;
        check("stall_ct", ct, ct_ref);
        check("stall_done_cnt", done_cnt, 1);
        check("stall_stable", stab_err, 0);

        run(pt, 1'b0, 1'b1, ct, cyc);
        check("restart_ct", ct, ct_ref);
        check("restart_done_cnt", done_cnt, 1);
        check("restart_key_cnt", rk_cnt, 11);
        check("restart_busy_after", busy_o, 1'b0);

        op_cnt = 0;
        @(negedge clk);
        pt_i = pt; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (op_cnt < 52 && cyc < 500) begin @(negedge clk); cyc++; end
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_reqs", {cu_req_o, rk_req_o, busy_o, done_o}, 4'b0000);
        check("midrst_ct", ct_o, 128'h0);
        check("midrst_ops", {cu_op_o, cu_rs1_o, cu_rs2_o, rk_idx_o}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        run(pt, 1'b0, 1'b0, ct, cyc);
        check("midrst_new_ct", ct, ct_ref);

`ifdef AES_SEQ_DECRYPT_EN
        dec_mode = 1;
        run(ct_ref, 1'b1, 1'b0, ct, cyc);
        check("dec_pt", ct, pt);
        check("dec_latency", cyc, 181);
        e = 0;
        for (int i = 0; i < 11; i++) if (rk_log[i] != 4'(10 - i)) e++;
        check("dec_key_order", e, 0);
        check("dec_op_first", op_log[0], 10'd184);
        check("dec_op_last", op_log[159], 10'd936);
        st1 = ct_ref ^ dec_rk[10];
        check("dec_rs2_col0_k1", rs2_log[1], st1[127:96]);
        dec_mode = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
